// File: rtl/bram_dump_reader.sv
// bram_dump_reader: sweeps BRAM addresses 0..MEMSIZE-1 through one read port
// and streams each word out on a valid/ready interface, tagging the last word.
// Optional feature: define BRAM_DUMP_CHECKSUM_EN to build the running-XOR
// checksum of accepted words on CHKSUM (otherwise CHKSUM is constant 0).
//
// Ports:
//   CLK, RST        clock and asynchronous active-high reset
//   START           pulse to begin a sweep (ignored while BUSY)
//   BUSY, DONE      sweep in progress / one-cycle pulse on last-word accept
//   EN, WE, ADDR, DI, DO   BRAM port (WE and DI tied to 0, read-only use)
//   DOUT, DOUT_VALID, DOUT_READY, DOUT_LAST   output stream
//   CHKSUM          XOR of accepted words since START
module bram_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned MEMSIZE    = 1,
  parameter int unsigned PIPELINED  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  EN,
  output logic                  WE,
  output logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] DI,
  input  logic [DATA_WIDTH-1:0] DO,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic                  DOUT_LAST,
  output logic [DATA_WIDTH-1:0] CHKSUM
);

  localparam int unsigned LAT = (PIPELINED != 0) ? 2 : 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMSIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  last_iss_q, last_iss_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LAT-1:0]        tag_v_q, tag_l_q;
  logic [CW-1:0]         infl_q, infl_d;
  logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic                  fifo_last_q [FIFO_DEPTH];

  logic issue_c, credit_c, push_c, pop_c, head_last_c, done_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits count words already buffered plus words still inside the BRAM
  // pipeline, so every issued read is guaranteed a FIFO slot on arrival.
  assign credit_c    = (32'(fifo_cnt_q) + 32'(infl_q)) < 32'(FIFO_DEPTH);
  assign push_c      = tag_v_q[LAT-1];
  assign DOUT_VALID  = (fifo_cnt_q != '0);
  assign pop_c       = DOUT_VALID & DOUT_READY;
  assign head_last_c = fifo_last_q[rd_ptr_q];
  assign done_c      = pop_c & head_last_c & (state_q == S_DRAIN);

  // Next-state and issue control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issue_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        if (credit_c) begin
          issue_c = 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (done_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    en_d       = issue_c;
    last_iss_d = issue_c & (cnt_q == LAST_ADDR);
    addr_d     = issue_c ? cnt_q : addr_q;
    fifo_cnt_d = fifo_cnt_q + CW'(push_c) - CW'(pop_c);
    infl_d     = infl_q + CW'(issue_c) - CW'(push_c);
  end

  // State, issue, tag pipeline and FIFO registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      last_iss_q <= 1'b0;
      addr_q     <= '0;
      tag_v_q    <= '0;
      tag_l_q    <= '0;
      infl_q     <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      last_iss_q <= last_iss_d;
      addr_q     <= addr_d;
      infl_q     <= infl_d;
      fifo_cnt_q <= fifo_cnt_d;
      // Tag stage 0 lines up with the cycle after EN; stage LAT-1 with DO.
      tag_v_q[0] <= en_q;
      tag_l_q[0] <= last_iss_q;
      for (int i = 1; i < int'(LAT); i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_l_q[i] <= tag_l_q[i-1];
      end
      if (push_c) begin
        fifo_data_q[wr_ptr_q] <= DO;
        fifo_last_q[wr_ptr_q] <= tag_l_q[LAT-1];
        wr_ptr_q              <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

`ifdef BRAM_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;

  // Running XOR of accepted words, restarted by an accepted START
  always_comb begin
    chk_d = chk_q;
    if ((state_q == S_IDLE) && START) begin
      chk_d = '0;
    end else if (pop_c) begin
      chk_d = chk_q ^ fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end

  assign CHKSUM = chk_q;
`else
  assign CHKSUM = '0;
`endif

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_c;
  assign EN        = en_q;
  assign WE        = 1'b0;
  assign ADDR      = addr_q;
  assign DI        = '0;
  assign DOUT      = fifo_data_q[rd_ptr_q];
  assign DOUT_LAST = head_last_c & DOUT_VALID;

endmodule

// File: tb/tb_bram_dump_reader.sv
// Bench for bram_dump_reader: three instances (latency 1, latency 2, and a
// 5-word sweep) each backed by a small behavioural BRAM read port.
module tb_bram_dump_reader;

`ifdef BRAM_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start, ready, busy, done, en, we, valid, last;
  logic [2:0] addr [3];
  logic [7:0] di [3];
  logic [7:0] do_ [3];
  logic [7:0] dout [3];
  logic [7:0] cks [3];
  logic [7:0] mem [8];
  logic [7:0] d1_q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bram_dump_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .MEMSIZE(8), .PIPELINED(0), .FIFO_DEPTH(4)) u_dut0 (
    .CLK(clk), .RST(rst), .START(start[0]), .BUSY(busy[0]), .DONE(done[0]),
    .EN(en[0]), .WE(we[0]), .ADDR(addr[0]), .DI(di[0]), .DO(do_[0]),
    .DOUT(dout[0]), .DOUT_VALID(valid[0]), .DOUT_READY(ready[0]),
    .DOUT_LAST(last[0]), .CHKSUM(cks[0]));

  bram_dump_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .MEMSIZE(8), .PIPELINED(1), .FIFO_DEPTH(4)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start[1]), .BUSY(busy[1]), .DONE(done[1]),
    .EN(en[1]), .WE(we[1]), .ADDR(addr[1]), .DI(di[1]), .DO(do_[1]),
    .DOUT(dout[1]), .DOUT_VALID(valid[1]), .DOUT_READY(ready[1]),
    .DOUT_LAST(last[1]), .CHKSUM(cks[1]));

  bram_dump_reader #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .MEMSIZE(5), .PIPELINED(0), .FIFO_DEPTH(4)) u_dut2 (
    .CLK(clk), .RST(rst), .START(start[2]), .BUSY(busy[2]), .DONE(done[2]),
    .EN(en[2]), .WE(we[2]), .ADDR(addr[2]), .DI(di[2]), .DO(do_[2]),
    .DOUT(dout[2]), .DOUT_VALID(valid[2]), .DOUT_READY(ready[2]),
    .DOUT_LAST(last[2]), .CHKSUM(cks[2]));

  // BRAM read ports: latency 1, and latency 2 with an output register
  always @(posedge clk) begin
    if (en[0]) do_[0] <= mem[addr[0]];
    if (en[1]) d1_q <= mem[addr[1]];
    do_[1] <= d1_q;
    if (en[2]) do_[2] <= mem[addr[2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // rmode 0: ready always high; 1: ready low through cycle 20; 2: random ready
  task automatic run_dump(input int d, input int n, input int rmode, input int exp_lat,
                          input bit midstart, input int stop_at, input string nm);
    int cyc, got, first, en_cnt, dones;
    logic [7:0] acc;
    cyc = 0; got = 0; first = -1; en_cnt = 0; dones = 0; acc = 8'h00;
    @(negedge clk);
    start[d] = 1'b1;
    ready[d] = (rmode == 0);
    while (got < stop_at && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start[d] = midstart && (cyc == 6);
      case (rmode)
        0:       ready[d] = 1'b1;
        1:       ready[d] = (cyc > 20);
        default: ready[d] = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 1) check({nm, "_busy_on"}, 32'(busy[d]), 32'd1);
      if (en[d]) en_cnt++;
      if (valid[d] && first < 0) first = cyc - 1;
      if (done[d]) dones++;
      if (rmode == 1 && cyc == 20) begin
        check({nm, "_stall_en_cnt"}, 32'(en_cnt), 32'd4);
        check({nm, "_stall_en_low"}, 32'(en[d]), 32'd0);
        check({nm, "_stall_valid"}, 32'(valid[d]), 32'd1);
      end
      if (valid[d] && ready[d]) begin
        check({nm, "_data"}, 32'(dout[d]), 32'(mem[got]));
        check({nm, "_last"}, 32'(last[d]), 32'(got == n - 1));
        check({nm, "_done"}, 32'(done[d]), 32'(got == n - 1));
        check({nm, "_chksum_run"}, 32'(cks[d]), CK ? 32'(acc) : 32'd0);
        acc = acc ^ dout[d];
        got++;
      end
    end
    check({nm, "_count"}, 32'(got), 32'(stop_at));
    check({nm, "_first_lat"}, 32'(first), 32'(exp_lat));
    if (stop_at == n) begin
      @(negedge clk);
      #1;
      check({nm, "_busy_off"}, 32'(busy[d]), 32'd0);
      check({nm, "_valid_off"}, 32'(valid[d]), 32'd0);
      check({nm, "_done_pulses"}, 32'(dones + int'(done[d])), 32'd1);
      check({nm, "_en_pulses"}, 32'(en_cnt), 32'(n));
      check({nm, "_chksum_final"}, 32'(cks[d]), CK ? 32'(acc) : 32'd0);
    end
  endtask

  task automatic check_reset(input int d, input string nm);
    check({nm, "_busy"}, 32'(busy[d]), 32'd0);
    check({nm, "_done"}, 32'(done[d]), 32'd0);
    check({nm, "_en"}, 32'(en[d]), 32'd0);
    check({nm, "_addr"}, 32'(addr[d]), 32'd0);
    check({nm, "_valid"}, 32'(valid[d]), 32'd0);
    check({nm, "_last"}, 32'(last[d]), 32'd0);
    check({nm, "_chksum"}, 32'(cks[d]), 32'd0);
    check({nm, "_we"}, 32'(we[d]), 32'd0);
    check({nm, "_di"}, 32'(di[d]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(3 * i + 1);
    rst   = 1'b1;
    start = '0;
    ready = '0;
    @(negedge clk);
    #1;
    check_reset(0, "rst0");
    check_reset(1, "rst1");
    @(negedge clk);
    rst = 1'b0;

    // T1 latency 1, ready high; checksum of 01..16 is 8'h10
    run_dump(0, 8, 0, 3, 1'b0, 8, "t1");
    check("t1_chksum_value", 32'(cks[0]), CK ? 32'h10 : 32'h00);

    // T2 latency 2
    run_dump(1, 8, 0, 4, 1'b0, 8, "t2");

    // T3 backpressure: issue stalls at FIFO depth
    run_dump(0, 8, 1, 3, 1'b0, 8, "t3");

    // T4 random ready, 5-word sweep, START pulsed mid-sweep
    run_dump(2, 5, 2, 3, 1'b1, 5, "t4");

    // T5 reset after 3 words, then a full re-dump from address 0
    run_dump(0, 8, 0, 3, 1'b0, 3, "t5a");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset(0, "t5_rst");
    @(negedge clk);
    rst      = 1'b0;
    ready[0] = 1'b0;
    run_dump(0, 8, 0, 3, 1'b0, 8, "t5b");

    // T6 checksum of A5,5A,FF followed by zeros is 8'h00
    mem[0] = 8'hA5;
    mem[1] = 8'h5A;
    mem[2] = 8'hFF;
    for (int i = 3; i < 8; i++) mem[i] = 8'h00;
    run_dump(0, 8, 0, 3, 1'b0, 8, "t6");
    check("t6_chksum_value", 32'(cks[0]), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
